// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Drains a FIFO from its read side and sends each word as an asynchronous
// UART frame: start bit, DATA_BITS data bits LSB first, an optional even
// parity bit, and one stop bit. Each bit lasts CLKS_PER_BIT clock cycles.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   tx_en        when low no new frame is started (a running frame completes)
//   fifo_empty   FIFO empty flag
//   fifo_dout    FIFO read data (valid whenever fifo_empty is low)
//   fifo_rd      FIFO pop strobe, one cycle per frame (combinational)
//   tx           serial line, idle high, registered
//   busy         high whenever the FSM is not in IDLE
//   tx_done      one-cycle pulse in the first IDLE cycle after a stop bit
//   dbg_state_o  current FSM state encoding (debug visibility)
//
// Pop handshake: ~fifo_empty acts as valid and (IDLE & tx_en & ~rst) as
// ready; a word transfers on every rising edge where fifo_rd is high, and
// fifo_dout is latched into the shift register on that same edge.
module fifo_uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_dout,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done,
  output logic [2:0]           dbg_state_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 pop;
  logic                 tick_last;
  logic                 bit_last;

  // Gated by rst so no pop can leak out while reset is held with the FSM
  // already forced into IDLE.
  assign pop       = (state_q == S_IDLE) & tx_en & ~fifo_empty & ~rst;
  assign tick_last = (tick_q == TW'(CLKS_PER_BIT - 1));
  assign bit_last  = (bit_q == BW'(DATA_BITS - 1));

  always_comb begin
    state_d = state_q;
    tick_d  = tick_last ? '0 : tick_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        if (pop) begin
          shreg_d = fifo_dout;
          par_d   = ^fifo_dout;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick_last) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (tick_last) begin
          shreg_d = shreg_q >> 1;
          if (bit_last) begin
            // Index is left at its final value rather than wrapping.
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick_last) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered, so its next value follows the next state; this
    // makes the start bit appear in the cycle right after the pop edge.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign fifo_rd     = pop;
  assign tx          = tx_q;
  assign busy        = (state_q != S_IDLE);
  assign tx_done     = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

- Serial transmitter that drains the team's FIFO from its read side and emits each word as an asynchronous UART frame on `tx`.
- Watches the FIFO `empty` flag, pops one word per frame with a single-cycle read strobe, and serializes it LSB first.
- Frame format: start bit, data bits, optional even parity bit, one stop bit.
- Sits between the FIFO's `rd`/`Dout`/`empty` pins and the board TX pin.

## Interface
Parameters:
- DATA_BITS, 8, word width and data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be ≥ 2.
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- tx_en  input  1  when low, no new frame is started; a frame in progress completes.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  DATA_BITS  FIFO read data; valid whenever fifo_empty is low.
- fifo_rd  output  1  FIFO pop strobe, one cycle per frame.
- tx  output  1  serial line, idle high, registered.
- busy  output  1  high whenever state ≠ IDLE.
- tx_done  output  1  one-cycle pulse after a stop bit completes, registered.

## Operation
States are IDLE, START, DATA, PARITY and STOP.
- **Reset values:** tx=1, busy=0, tx_done=0, fifo_rd=0, state=IDLE, counters=0.
- **IDLE:**
  - fifo_rd = (state==IDLE) & tx_en & ~fifo_empty, combinational.
  - At the same edge, fifo_dout is latched into the shift register and the state moves to START.
  - fifo_empty and fifo_dout are ignored in every other state.
- **START:** tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- **DATA:**
  - tx = shreg[0] for CLKS_PER_BIT cycles.
  - Then shift right and increment the bit index.
  - After bit DATA_BITS-1, go to PARITY if PARITY_EN, else to STOP.
- **PARITY:** tx = XOR of all latched data bits (even parity) for CLKS_PER_BIT cycles, then STOP.
- **STOP:** tx=1 for CLKS_PER_BIT cycles, then IDLE with tx_done=1 for exactly that first IDLE cycle.
- **Counters:**
  - Tick counter is $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, and clears on every bit boundary.
  - Bit index is $clog2(DATA_BITS) bits and never wraps within a frame.
- **Back-to-back:** in the IDLE cycle carrying tx_done, a new pop is allowed if tx_en & ~fifo_empty. No extra idle gap is inserted.
- **tx_en:** dropping mid-frame does not abort the frame. It only blocks the next pop.
- **Reset mid-frame:**
  - tx returns high immediately (asynchronously) and the state goes to IDLE.
  - The popped word is discarded and not re-read.
  - No tx_done is generated.
- **Empty FIFO:** fifo_rd is never asserted while fifo_empty=1, so no underflow pops occur.

## Timing
- **Pop to start bit:** the pop occurs in IDLE cycle c0. tx falls at the edge ending c0, so the start bit begins in cycle c0+1.
- **Frame length:** F = (2 + DATA_BITS + PARITY_EN) × CLKS_PER_BIT cycles of tx activity.
- **Bit k boundaries:** data bit k occupies cycles c0+1+(1+k)×CLKS_PER_BIT through c0+(2+k)×CLKS_PER_BIT.
- **tx_done:** high in cycle c0+F+1, which is the first IDLE cycle.
- **Continuous throughput:** with the FIFO never empty, one pop every F+1 cycles. Adjacent stop and start bits touch, with no extra high cycle beyond the single IDLE cycle.
- **busy:** high from c0+1 through c0+F; low in the tx_done cycle.
- **fifo_rd width:** exactly one cycle per frame, coincident with the data latch edge. This matches the FIFO's combinational Dout at the read pointer.

## Test plan
- **Single word:** DATA_BITS=8, CLKS_PER_BIT=4, PARITY_EN=0; one word 0xA5 in the FIFO, tx_en=1.
  - Exactly one fifo_rd pulse.
  - tx (4 cycles each) reads 0, 1,0,1,0,0,1,0,1, 1.
  - tx_done at c0+41; busy high for 40 cycles.
- **Back-to-back:** 0x01, 0x80, 0xFF written before tx_en rises.
  - Three fifo_rd pulses spaced 41 cycles apart.
  - Three correct frames; fifo_empty is high after the third pop and no fourth pop occurs.
- **Parity:** PARITY_EN=1 with 0x07 gives parity bit 1; 0x03 gives parity bit 0. Frame length is 44 cycles at CLKS_PER_BIT=4.
- **tx_en gating:**
  - FIFO holds 2 words and tx_en drops during the first frame's DATA state.
  - The first frame completes with tx_done.
  - No second pop and tx stays 1 until tx_en returns; then the second frame starts the cycle after.
- **Reset mid-frame:** assert rst during data bit 3.
  - tx=1, busy=0 and fifo_rd=0 immediately, with no tx_done.
  - After release with a non-empty FIFO, the next word is popped and sent intact.
- **Empty idle:** fifo_empty=1 for 200 cycles gives fifo_rd=0, tx=1 and busy=0 throughout.
